mac_accumulator: RTL

Consumer end of the multiplier product interface. Accepts a stream of signed Q8.24 products from the DSP multiply unit and sums DOT_LEN of them onto a Q4.12 bias. Rounds and rescales the sum back to Q4.12, saturates it, and optionally applies ReLU. Sits between the mac_unit product output and the hidden/feature buffer. It is the >>12 rescale stage that the multiplier leaves to external logic.

---
 rtl/mac_accumulator.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/mac_accumulator.sv
// Dot-product accumulator: sums DOT_LEN signed Q8.24 products onto a Q4.12 bias,
// then rounds, rescales to Q4.12, saturates and optionally applies ReLU.
module mac_accumulator #(
  parameter int unsigned DOT_LEN = 16,
  parameter int unsigned ACC_W   = 40,
  parameter int unsigned SHIFT   = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] bias,
  input  logic        relu_en,
  input  logic        prod_valid,
  input  logic [31:0] product,
  output logic [15:0] result,
  output logic        result_valid,
  output logic        sat_flag,
  output logic        busy,
  output logic        err
);

  localparam int unsigned CNT_W = $clog2(DOT_LEN + 1);
  localparam int unsigned RW    = ACC_W - SHIFT;

  typedef enum logic [1:0] {IDLE, ACCUM, ROUND, OUT} state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               relu_q, relu_d;
  logic [RW-1:0]      r_q, r_d;
  logic [15:0]        result_q, result_d;
  logic               rv_q, rv_d;
  logic               sat_q, sat_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;

  logic [ACC_W-1:0]   bias_ext;
  logic [ACC_W-1:0]   prod_ext;
  logic [ACC_W-1:0]   rnd;
  logic [ACC_W:0]     sum_chk;
  logic               fits;
  logic [15:0]        sat_val;

  // Operand alignment; sum_chk carries one guard bit to detect accumulator wrap.
  assign bias_ext = {{(ACC_W-16){bias[15]}}, bias} << SHIFT;
  assign prod_ext = {{(ACC_W-32){product[31]}}, product};
  assign sum_chk  = {acc_q[ACC_W-1], acc_q} + {prod_ext[ACC_W-1], prod_ext};
  assign rnd      = acc_q + (ACC_W'(1) << (SHIFT - 1));

  // r fits in 16 bits when every bit above bit 15 matches the sign.
  assign fits    = (&r_q[RW-1:15]) | ~(|r_q[RW-1:15]);
  assign sat_val = fits ? r_q[15:0] : (r_q[RW-1] ? 16'h8000 : 16'h7FFF);

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    relu_d   = relu_q;
    r_d      = r_q;
    result_d = result_q;
    rv_d     = 1'b0;
    sat_d    = sat_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (prod_valid) err_d = 1'b1;
        if (start) begin
          acc_d   = bias_ext;
          cnt_d   = '0;
          relu_d  = relu_en;
          err_d   = 1'b0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (prod_valid) begin
          acc_d = sum_chk[ACC_W-1:0];
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DOT_LEN - 1)) state_d = ROUND;
        end
      end
      ROUND: begin
        if (prod_valid) err_d = 1'b1;
        r_d     = rnd[ACC_W-1:SHIFT];
        state_d = OUT;
      end
      OUT: begin
        if (prod_valid) err_d = 1'b1;
        result_d = (relu_q && sat_val[15]) ? 16'h0000 : sat_val;
        sat_d    = ~fits;
        rv_d     = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      relu_q   <= 1'b0;
      r_q      <= '0;
      result_q <= '0;
      rv_q     <= 1'b0;
      sat_q    <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      relu_q   <= relu_d;
      r_q      <= r_d;
      result_q <= result_d;
      rv_q     <= rv_d;
      sat_q    <= sat_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  // Guards the ACC_W sizing rule: an accepted product must never wrap the sum.
  always_ff @(posedge clk) begin
    if (!rst && state_q == ACCUM && prod_valid) begin
      assert (sum_chk[ACC_W] == sum_chk[ACC_W-1])
        else $error("mac_accumulator: accumulator overflow, ACC_W too small");
    end
  end

  assign result       = result_q;
  assign result_valid = rv_q;
  assign sat_flag     = sat_q;
  assign busy         = busy_q;
  assign err          = err_q;

endmodule
